// File: rtl/arbiter_requester_pkg.sv
// Shared types and width helpers for the arbiter requester block.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Bits needed to hold the values 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arbiter_requester_if.sv
// Request/grant bundle between a requester block and its environment.
interface arbiter_requester_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] push_i;
  logic [NUM_REQ-1:0] push_ready_o;
  logic [NUM_REQ-1:0] req_o;
  logic               req_en_o;
  logic [NUM_REQ-1:0] grant_i;
  logic [NUM_REQ-1:0] done_o;
  logic               timeout_o;
  logic               busy_o;

  modport master (
    input  push_i, grant_i,
    output push_ready_o, req_o, req_en_o, done_o, timeout_o, busy_o
  );

  modport slave (
    output push_i, grant_i,
    input  push_ready_o, req_o, req_en_o, done_o, timeout_o, busy_o
  );
endinterface

// File: rtl/arbiter_requester_pending_counter.sv
// Per-channel pending-request counter, saturating at DEPTH and at zero.
module pending_counter
  import arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic nonzero_o
);
  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] count_q, count_d;

  assign full_o    = (count_q == CW'(DEPTH));
  assign nonzero_o = (count_q != '0);

  // A simultaneous push and service cancel out, even when full.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i && nonzero_o) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/arbiter_requester.sv
// Collects per-channel pending requests and runs issue/wait rounds against an
// external arbiter, retiring granted channels or abandoning the round on timeout.
module arbiter_requester
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic                 clk_i,
  input logic                 rst_i,
  arbiter_requester_if.master bus
);
  // state    | meaning
  // ST_IDLE  | no round open; start one when any channel has pending work
  // ST_ISSUE | request vector presented with req_en_o for this single cycle
  // ST_WAIT  | holding req_o, waiting for a grant hit or the timeout

  localparam int TW = cnt_width(TIMEOUT);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_q, req_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               req_en_q, req_en_d;
  logic               tmo_q, tmo_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] nonzero;
  logic [NUM_REQ-1:0] hit;

  // Grants only count against the channels we actually asked for.
  assign hit = (state_q != ST_IDLE) ? (bus.grant_i & req_q) : '0;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_chan
    pending_counter #(
      .DEPTH(DEPTH)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (bus.push_i[k]),
      .dec_i    (hit[k]),
      .full_o   (full[k]),
      .nonzero_o(nonzero[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    req_en_d = 1'b0;
    done_d   = '0;
    tmo_d    = 1'b0;
    tcnt_d   = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|nonzero) begin
          state_d  = ST_ISSUE;
          req_d    = nonzero;
          req_en_d = 1'b1;
          tcnt_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (|hit) begin
          done_d  = hit;
          req_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (|hit) begin
          done_d  = hit;
          req_d   = '0;
          state_d = ST_IDLE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          req_d   = '0;
          tcnt_d  = TW'(TIMEOUT);
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      req_en_q <= 1'b0;
      done_q   <= '0;
      tmo_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      req_en_q <= req_en_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign bus.push_ready_o = ~full;
  assign bus.req_o        = req_q;
  assign bus.req_en_o     = req_en_q;
  assign bus.done_o       = done_q;
  assign bus.timeout_o    = tmo_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_arbiter_requester.sv
// Bench for arbiter_requester: round-level reference model, bench-side arbiters,
// directed scenarios and randomized traffic.
module tb_arbiter_requester;
  localparam int N = 4;
  localparam int D = 4;
  localparam int T = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_requester_if #(.NUM_REQ(N)) bus ();

  arbiter_requester #(
    .NUM_REQ(N),
    .DEPTH  (D),
    .TIMEOUT(T)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int cmp_pass = 0, cmp_total = 0;
  int lit_pass = 0, lit_total = 0;
  int cyc = 0;
  int arb_mode = 0;  // 0 tied low, 1 fixed priority, 2 round robin, 3 random noise

  int           en_log[$];
  int           tmo_log[$];
  logic [N-1:0] done_log[$];

  always @(posedge clk) cyc++;

  // ---------------- bench-side arbiter (registered grant) ----------------
  logic         prev_en = 1'b0;
  logic [N-1:0] prev_req = '0;
  int           rr_ptr = N - 1;

  always @(posedge clk) begin
    logic [N-1:0] g;
    int           start;
    #2;
    g = '0;
    if (rst) rr_ptr = N - 1;
    case (arb_mode)
      1: if (prev_en) begin
           for (int k = N - 1; k >= 0; k--) if (prev_req[k] && g == '0) g[k] = 1'b1;
         end
      2: if (prev_en) begin
           start = rr_ptr;
           for (int s = 0; s < N; s++) begin
             int idx;
             idx = (start - s + N) % N;
             if (prev_req[idx] && g == '0) begin
               g[idx] = 1'b1;
               rr_ptr = (idx - 1 + N) % N;
             end
           end
         end
      3: g = N'($urandom_range(0, (1 << N) - 1));
      default: g = '0;
    endcase
    bus.grant_i = g;
    prev_en  = bus.req_en_o;
    prev_req = bus.req_o;
  end

  // ---------------- behavioural reference model (round level) ----------------
  int           mcnt[N];
  bit           m_act, m_first;
  int           m_wait;
  logic [N-1:0] m_mask, e_done, m_hit, m_nz;
  bit           e_en, e_tmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) mcnt[k] = 0;
      m_act = 0; m_first = 0; m_wait = 0;
      m_mask = '0; e_done = '0; e_en = 0; e_tmo = 0;
    end else begin
      m_hit = m_act ? (bus.grant_i & m_mask) : '0;
      for (int k = 0; k < N; k++) m_nz[k] = (mcnt[k] > 0);
      e_done = '0; e_en = 0; e_tmo = 0;
      if (!m_act) begin
        if (m_nz != '0) begin
          m_act = 1; m_first = 1; m_mask = m_nz; m_wait = 0; e_en = 1;
        end
      end else if (m_hit != '0) begin
        e_done = m_hit; m_act = 0; m_mask = '0;
      end else begin
        if (!m_first) m_wait++;
        m_first = 0;
        if (m_wait == T) begin
          e_tmo = 1; m_act = 0; m_mask = '0;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (bus.push_i[k] && (mcnt[k] < D || m_hit[k])) mcnt[k]++;
        if (m_hit[k]) mcnt[k]--;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input int act, input int exp);
    cmp_total++;
    if (act == exp) cmp_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    logic [N-1:0] rdy;
    if (!rst) begin
      for (int k = 0; k < N; k++) rdy[k] = (mcnt[k] < D);
      cmp("req_o",        int'(bus.req_o),        int'(m_mask));
      cmp("req_en_o",     int'(bus.req_en_o),     int'(e_en));
      cmp("done_o",       int'(bus.done_o),       int'(e_done));
      cmp("timeout_o",    int'(bus.timeout_o),    int'(e_tmo));
      cmp("busy_o",       int'(bus.busy_o),       int'(m_act));
      cmp("push_ready_o", int'(bus.push_ready_o), int'(rdy));
      if (bus.req_en_o) en_log.push_back(cyc);
      if (bus.timeout_o) tmo_log.push_back(cyc);
      if (bus.done_o != '0) done_log.push_back(bus.done_o);
    end
  end

  // ---------------- directed / random stimulus ----------------
  task automatic lit(input string name, input int act, input int exp);
    lit_total++;
    if (act == exp) lit_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at posedge+2; push is captured at the next rising edge.
  task automatic push_once(input logic [N-1:0] v);
    bus.push_i = v;
    @(posedge clk); #2;
    bus.push_i = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    bus.push_i = '0;
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input int base, input int n, input int limit);
    int c;
    c = 0;
    while (done_log.size() < base + n && c < limit) begin
      @(posedge clk); #2; c++;
    end
    lit("done_count", done_log.size() - base, n);
  endtask

  function automatic int msum();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += mcnt[k];
    return s;
  endfunction

  initial begin
    int b, eb, tb;
    bus.push_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    lit("rst_req_o", int'(bus.req_o), 0);
    lit("rst_req_en_o", int'(bus.req_en_o), 0);
    lit("rst_busy_o", int'(bus.busy_o), 0);
    lit("rst_done_o", int'(bus.done_o), 0);
    lit("rst_timeout_o", int'(bus.timeout_o), 0);
    lit("rst_push_ready_o", int'(bus.push_ready_o), 'hf);
    @(posedge clk); #2;

    // Fixed priority: one push on all channels, four rounds MSB first.
    arb_mode = 1;
    b = done_log.size(); eb = en_log.size();
    push_once(4'b1111);
    wait_done(b, 4, 60);
    if (done_log.size() >= b + 4) begin
      lit("fixed_done0", int'(done_log[b]),     'h8);
      lit("fixed_done1", int'(done_log[b + 1]), 'h4);
      lit("fixed_done2", int'(done_log[b + 2]), 'h2);
      lit("fixed_done3", int'(done_log[b + 3]), 'h1);
    end
    idle_cycles(4);
    lit("fixed_busy_end", int'(bus.busy_o), 0);
    lit("fixed_counts_end", msum(), 0);
    lit("fixed_rounds", en_log.size() - eb, 4);
    if (en_log.size() >= eb + 2) lit("fixed_round_spacing", en_log[eb + 1] - en_log[eb], 3);

    // Round robin: two pushes on channels 3 and 0.
    do_reset();
    arb_mode = 2;
    b = done_log.size();
    push_once(4'b1001);
    push_once(4'b1001);
    wait_done(b, 4, 80);
    if (done_log.size() >= b + 4) begin
      lit("rr_done0", int'(done_log[b]),     'h8);
      lit("rr_done1", int'(done_log[b + 1]), 'h1);
      lit("rr_done2", int'(done_log[b + 2]), 'h8);
      lit("rr_done3", int'(done_log[b + 3]), 'h1);
    end

    // Timeout with grant tied low.
    do_reset();
    arb_mode = 0;
    eb = en_log.size(); tb = tmo_log.size();
    push_once(4'b0001);
    idle_cycles(T + 6);
    lit("tmo_pulses", tmo_log.size() - tb, 1);
    lit("tmo_issues", en_log.size() - eb, 2);
    if (tmo_log.size() > tb && en_log.size() > eb + 1) begin
      lit("tmo_after_issue", tmo_log[tb] - en_log[eb], T + 1);
      lit("tmo_reissue", en_log[eb + 1] - tmo_log[tb], 1);
    end
    lit("tmo_count0", mcnt[0], 1);

    // Saturation: five back-to-back pushes on channel 0.
    do_reset();
    arb_mode = 0;
    push_once(4'b0001);
    push_once(4'b0001);
    push_once(4'b0001);
    lit("sat_ready_after3", int'(bus.push_ready_o[0]), 1);
    push_once(4'b0001);
    lit("sat_ready_after4", int'(bus.push_ready_o[0]), 0);
    push_once(4'b0001);
    idle_cycles(2);
    lit("sat_count0", mcnt[0], 4);
    lit("sat_ready_after5", int'(bus.push_ready_o[0]), 0);

    // Same-edge push and service on channel 2.
    do_reset();
    arb_mode = 1;
    b = done_log.size();
    push_once(4'b0100);
    idle_cycles(2);
    push_once(4'b0100);
    lit("same_edge_count2", mcnt[2], 1);
    wait_done(b, 2, 40);
    if (done_log.size() >= b + 2) begin
      lit("same_edge_done0", int'(done_log[b]),     'h4);
      lit("same_edge_done1", int'(done_log[b + 1]), 'h4);
    end
    lit("same_edge_count_end", mcnt[2], 0);

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    arb_mode = 0;
    push_once(4'b0001);
    idle_cycles(5);
    lit("mid_busy_before", int'(bus.busy_o), 1);
    #1 rst = 1'b1;
    #1;
    lit("mid_req_o", int'(bus.req_o), 0);
    lit("mid_busy_o", int'(bus.busy_o), 0);
    lit("mid_req_en_o", int'(bus.req_en_o), 0);
    lit("mid_push_ready_o", int'(bus.push_ready_o), 'hf);
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    b = done_log.size(); eb = en_log.size(); tb = tmo_log.size();
    @(posedge clk); #2;
    idle_cycles(T + 8);
    lit("mid_no_done", done_log.size() - b, 0);
    lit("mid_no_timeout", tmo_log.size() - tb, 0);
    lit("mid_no_issue", en_log.size() - eb, 0);

    // Randomized traffic under each arbiter flavour.
    do_reset();
    for (int m = 3; m >= 1; m--) begin
      arb_mode = m;
      repeat (800) begin
        bus.push_i = N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1));
        @(posedge clk); #2;
      end
    end
    bus.push_i = '0;
    arb_mode = 1;
    idle_cycles(120);
    lit("rand_drained", msum(), 0);
    lit("rand_busy_end", int'(bus.busy_o), 0);

    $display("%0d/%0d checks passed", cmp_pass + lit_pass, cmp_total + lit_total);
    $finish;
  end
endmodule

// File: doc/arbiter_requester.md
ARBITER_REQUESTER -- requirements
Module: arbiter_requester

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of request channels; grant width equals NUM_REQ.
REQ-002 SHALL have parameter DEPTH, default 4, maximum pending requests per channel (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before abandoning a round (>=1).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port push_i  input  NUM_REQ  per-channel request enqueue strobe.
REQ-007 SHALL have port push_ready_o  output  NUM_REQ  channel k can accept a push (count_k < DEPTH).
REQ-008 SHALL have port req_o  output  NUM_REQ  request vector to arbiter.
REQ-009 SHALL have port req_en_o  output  1  one-cycle request-valid strobe to arbiter.
REQ-010 SHALL have port grant_i  input  NUM_REQ  grant vector from arbiter; bit k maps to channel k.
REQ-011 SHALL have port done_o  output  NUM_REQ  one-cycle pulse, channels serviced this round.
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse, round abandoned.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL keep a counter count_k per channel, width clog2(DEPTH+1), range 0..DEPTH.
REQ-015 SHALL increment count_k at an edge where push_i[k]=1 and count_k<DEPTH; push at count_k=DEPTH SHALL be dropped with no other effect.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-017 IDLE: if any count_k>0, SHALL go to ISSUE, registering req_o <= {count_k!=0} and req_en_o <= 1; else stay.
REQ-018 ISSUE: lasts exactly one cycle (req_en_o high only here), then WAIT with req_en_o <= 0, req_o held.
REQ-019 In ISSUE and WAIT, at each edge SHALL sample hit = grant_i & req_o; if hit!=0: done_o <= hit for one cycle, count_k decremented for each set bit, req_o <= 0, go IDLE.
REQ-020 Grant bits not in req_o, and any grant_i in IDLE, SHALL be ignored.
REQ-021 Timeout counter SHALL clear on entering ISSUE and increment each WAIT cycle with hit=0; on reaching TIMEOUT SHALL pulse timeout_o, clear req_o, go IDLE, leave counts unchanged.
REQ-022 Same-edge push and grant decrement on one channel SHALL leave count_k unchanged (push accepted even if count_k=DEPTH at that edge).
REQ-023 Pushes SHALL be accepted in every state; channels pushed after ISSUE join the next round only.
REQ-024 Latency: push at edge t into empty block SHALL yield req_en_o high after edge t+1; minimum round IDLE->IDLE is 2 cycles, so back-to-back rounds issue every 3 cycles.
REQ-025 push_ready_o SHALL be combinational from count_k; all other outputs registered.

Reset
REQ-026 rst_i high SHALL asynchronously force state IDLE, all count_k=0, req_o=0, req_en_o=0, done_o=0, timeout_o=0, timeout counter=0; push_ready_o all ones; mid-round reset discards all pending requests.

Structure
REQ-027 SHALL place the FSM state enum typedef and clog2-derived width helpers in shared package arbiter_pkg.
REQ-028 SHALL use sub-module pending_counter (one instance per channel: saturating up/down counter with inc, dec, full, nonzero outputs).

Verification
REQ-029 Bench with fixed_priority_arbiter (REG_OUT=1): push 4'b1111 once -> rounds grant 1000,0100,0010,0001; done_o pulses match; counts end 0; busy_o then low.
REQ-030 With round_robin_arbiter: push 4'b1001 twice -> done_o sequence 1000,0001,1000,0001.
REQ-031 grant_i tied 0, push channel 0 -> req_en_o once, timeout_o after 15 WAIT cycles, re-issue next cycle in IDLE, count_0 stays 1.
REQ-032 Push channel 0 five times back-to-back, grant_i 0 -> push_ready_o[0] low after 4th, 5th dropped, count_0=4.
REQ-033 count_2=1, push_i[2] on same edge as hit on channel 2 -> count_2 stays 1, done_o=0100, new round follows.
REQ-034 Assert rst_i asynchronously mid-WAIT -> outputs zero immediately, state IDLE, counts 0, no done_o/timeout_o pulse after release.
